// File: rtl/score_scan_if.sv
// Bundle between the game controller (master) and the Pong score keeper / digit scanner (slave).
interface score_scan_if;
  // point_p1/point_p2 are level requests: a point counts once per low-to-high transition,
  // and the input must be low for at least one cycle before it can count again. clear is a
  // single-cycle strobe. All outputs are registered and change only on clock edges.
  logic       point_p1;
  logic       point_p2;
  logic       clear;
  logic [3:0] p1_tens;
  logic [3:0] p1_units;
  logic [3:0] p2_tens;
  logic [3:0] p2_units;
  logic [1:0] sel;
  logic [3:0] an;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output point_p1, point_p2, clear,
    input  p1_tens, p1_units, p2_tens, p2_units, sel, an, game_over, winner
  );

  modport slave (
    input  point_p1, point_p2, clear,
    output p1_tens, p1_units, p2_tens, p2_units, sel, an, game_over, winner
  );
endinterface

// File: rtl/score_scan.sv
// Pong score keeper: two-digit BCD scores, win detection and the rotating digit
// select / active-low anode drive for the 4:1 seven-segment multiplexer.
module score_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int WIN_SCORE   = 10
) (
  input  logic         clk,
  input  logic         rst,
  score_scan_if.slave  bus
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [7:0]    WIN_BCD  = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  // The game FSM state is visible on the game_over output.
  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } game_state_t;

  game_state_t   state, state_n;
  logic [1:0]    s1, s2, pulse;
  logic [7:0]    p1_q, p2_q, p1_n, p2_n;
  logic [1:0]    winner_q, winner_n;
  logic          hit1, hit2;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [1:0]    sel_q, sel_n;
  logic [3:0]    an_q, an_n;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Bit 0 tracks player 1, bit 1 tracks player 2.
  assign pulse = s1 & ~s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      state    <= ST_PLAY;
      p1_q     <= '0;
      p2_q     <= '0;
      winner_q <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      an_q     <= 4'b1111;
    end else begin
      s1       <= {bus.point_p2, bus.point_p1};
      s2       <= s1;
      state    <= state_n;
      p1_q     <= p1_n;
      p2_q     <= p2_n;
      winner_q <= winner_n;
      cnt_q    <= cnt_n;
      sel_q    <= sel_n;
      an_q     <= an_n;
    end
  end

  always_comb begin
    state_n  = state;
    p1_n     = p1_q;
    p2_n     = p2_q;
    winner_n = winner_q;
    hit1     = 1'b0;
    hit2     = 1'b0;
    // clear has priority, so a point arriving in the same cycle is dropped.
    if (bus.clear) begin
      state_n  = ST_PLAY;
      p1_n     = '0;
      p2_n     = '0;
      winner_n = '0;
    end else if (state == ST_PLAY) begin
      if (pulse[0]) p1_n = bcd_inc(p1_q);
      if (pulse[1]) p2_n = bcd_inc(p2_q);
      hit1 = (p1_n == WIN_BCD);
      hit2 = (p2_n == WIN_BCD);
      if (hit1 || hit2) begin
        state_n  = ST_OVER;
        winner_n = {hit2, hit1};
      end
    end
  end

  // an is computed from next-state sel and scores so it moves on the same edge as sel.
  always_comb begin
    cnt_n = cnt_q + CW'(1);
    sel_n = sel_q;
    an_n  = 4'b1111;
    if (cnt_q == CNT_LAST) begin
      cnt_n = '0;
      sel_n = sel_q + 2'd1;
    end
    case (sel_n)
      2'd0:    an_n = (p1_n[7:4] == 4'd0) ? 4'b1111 : 4'b0111;
      2'd1:    an_n = 4'b1011;
      2'd2:    an_n = (p2_n[7:4] == 4'd0) ? 4'b1111 : 4'b1101;
      default: an_n = 4'b1110;
    endcase
  end

  assign bus.p1_tens   = p1_q[7:4];
  assign bus.p1_units  = p1_q[3:0];
  assign bus.p2_tens   = p2_q[7:4];
  assign bus.p2_units  = p2_q[3:0];
  assign bus.sel       = sel_q;
  assign bus.an        = an_q;
  assign bus.game_over = (state == ST_OVER);
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_score_scan.sv
// Bench for score_scan: two instances (WIN_SCORE 3 and 99, REFRESH_DIV 4) with
// directed stimulus and a queue-based scoreboard checked by an independent monitor.
module tb_score_scan;

  localparam int W = 25;
  // Observation vector: p1_tens,p1_units,p2_tens,p2_units,sel,an,game_over,winner
  localparam logic [W-1:0] M_ALL   = '1;
  localparam logic [W-1:0] M_SCORE = {16'hFFFF, 9'h000};
  localparam logic [W-1:0] M_GAME  = {22'h0, 3'b111};
  localparam logic [W-1:0] M_SCAN  = {16'h0000, 2'b11, 4'hF, 3'b000};
  localparam logic [W-1:0] M_SG    = M_SCORE | M_GAME;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   rst_edge = 0;
  int   checks = 0;
  int   failures = 0;

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  score_scan_if ifa ();
  score_scan_if ifb ();

  score_scan #(.REFRESH_DIV(4), .WIN_SCORE(3))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
  score_scan #(.REFRESH_DIV(4), .WIN_SCORE(99)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [W-1:0] obs_a, obs_b, got;
  assign obs_a = {ifa.p1_tens, ifa.p1_units, ifa.p2_tens, ifa.p2_units,
                  ifa.sel, ifa.an, ifa.game_over, ifa.winner};
  assign obs_b = {ifb.p1_tens, ifb.p1_units, ifb.p2_tens, ifb.p2_units,
                  ifb.sel, ifb.an, ifb.game_over, ifb.winner};

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  int           due_q[$];
  int           dut_q[$];
  string        name_q[$];

  function automatic logic [W-1:0] pack(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [3:0] d,
                                        input logic [1:0] s, input logic [3:0] n,
                                        input logic g, input logic [1:0] w);
    return {a, b, c, d, s, n, g, w};
  endfunction

  task automatic expect_at(input int dut, input string name, input int due,
                           input logic [W-1:0] exp, input logic [W-1:0] mask);
    exp_q.push_back(exp);
    mask_q.push_back(mask);
    due_q.push_back(due);
    dut_q.push_back(dut);
    name_q.push_back(name);
  endtask

  task automatic check_now(input string name, input logic [W-1:0] g,
                           input logic [W-1:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, g, e);
    end
  endtask

  // monitor: compares every queued expectation whose cycle has come
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (due_q[i] == cyc) begin
        got = ((dut_q[i] == 0) ? obs_a : obs_b) & mask_q[i];
        checks++;
        if (got !== (exp_q[i] & mask_q[i])) begin
          failures++;
          $display("FAIL %s dut=%0d cyc=%0d got=%h expected=%h", name_q[i], dut_q[i],
                   cyc, got, exp_q[i] & mask_q[i]);
        end
        exp_q.delete(i);
        mask_q.delete(i);
        due_q.delete(i);
        dut_q.delete(i);
        name_q.delete(i);
      end
    end
  end

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pts(input int dut, input logic a, input logic b);
    if (dut == 0) begin
      ifa.point_p1 = a;
      ifa.point_p2 = b;
    end else begin
      ifb.point_p1 = a;
      ifb.point_p2 = b;
    end
  endtask

  task automatic pulse(input int dut, input logic a, input logic b);
    set_pts(dut, a, b);
    step();
    set_pts(dut, 1'b0, 1'b0);
    step();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    step(cycles);
    rst = 1'b0;
    rst_edge = cyc;
  endtask

  logic [3:0] an_b[4];
  logic [3:0] an_a[4];
  logic [1:0] e_sel;
  int         n0;

  initial begin
    ifa.point_p1 = 1'b0; ifa.point_p2 = 1'b0; ifa.clear = 1'b0;
    ifb.point_p1 = 1'b0; ifb.point_p2 = 1'b0; ifb.clear = 1'b0;
    an_b = '{4'h7, 4'hB, 4'hF, 4'hE};  // p1=12, p2=05
    an_a = '{4'hF, 4'hB, 4'hF, 4'hE};  // p1=01, p2=00

    // reset state
    do_reset(2);
    check_now("reset_now_a", obs_a, pack(0, 0, 0, 0, 2'd0, 4'hF, 1'b0, 2'd0));
    check_now("reset_now_b", obs_b, pack(0, 0, 0, 0, 2'd0, 4'hF, 1'b0, 2'd0));
    expect_at(0, "reset_a", cyc, pack(0, 0, 0, 0, 2'd0, 4'hF, 1'b0, 2'd0), M_ALL);
    expect_at(1, "reset_b", cyc, pack(0, 0, 0, 0, 2'd0, 4'hF, 1'b0, 2'd0), M_ALL);

    // counting on the WIN_SCORE=99 instance
    for (int i = 0; i < 9; i++) begin
      pulse(1, 1'b1, 1'b0);
      expect_at(1, "count", cyc, pack(0, 4'(i + 1), 0, 0, 0, 0, 1'b0, 2'd0), M_SG);
    end
    pulse(1, 1'b1, 1'b0);
    expect_at(1, "units_carry", cyc, pack(1, 0, 0, 0, 0, 0, 1'b0, 2'd0), M_SG);
    pulse(1, 1'b1, 1'b0);
    pulse(1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) pulse(1, 1'b0, 1'b1);
    expect_at(1, "score_12_05", cyc, pack(1, 2, 0, 5, 0, 0, 1'b0, 2'd0), M_SG);

    // scan: 4 cycles per slot, an from hand table, p2_tens blanked
    for (int k = 0; k < 20; k++) begin
      e_sel = 2'(((cyc - rst_edge) / 4) % 4);
      expect_at(1, "scan", cyc, pack(1, 2, 0, 5, e_sel, an_b[e_sel], 1'b0, 2'd0), M_ALL);
      step();
    end

    // held level and latency on the WIN_SCORE=3 instance
    n0 = cyc;
    ifa.point_p2 = 1'b1;
    expect_at(0, "lat_edge1", n0 + 1, pack(0, 0, 0, 0, 0, 0, 1'b0, 2'd0), M_SG);
    expect_at(0, "lat_edge2", n0 + 2, pack(0, 0, 0, 1, 0, 0, 1'b0, 2'd0), M_SG);
    step(20);
    expect_at(0, "held_once", cyc, pack(0, 0, 0, 1, 0, 0, 1'b0, 2'd0), M_SG);
    ifa.point_p2 = 1'b0;
    step();

    // simultaneous win
    pulse(0, 1'b1, 1'b0);
    pulse(0, 1'b1, 1'b0);
    pulse(0, 1'b0, 1'b1);
    expect_at(0, "both_at_2", cyc, pack(0, 2, 0, 2, 0, 0, 1'b0, 2'd0), M_SG);
    n0 = cyc;
    expect_at(0, "tie_pre", n0 + 1, pack(0, 2, 0, 2, 0, 0, 1'b0, 2'd0), M_SG);
    expect_at(0, "tie_win", n0 + 2, pack(0, 3, 0, 3, 0, 0, 1'b1, 2'd3), M_SG);
    pulse(0, 1'b1, 1'b1);
    pulse(0, 1'b1, 1'b1);
    pulse(0, 1'b1, 1'b0);
    expect_at(0, "over_hold", cyc, pack(0, 3, 0, 3, 0, 0, 1'b1, 2'd3), M_SG);

    // clear vs point, from game over
    set_pts(0, 1'b1, 1'b0);
    step();
    ifa.clear = 1'b1;
    set_pts(0, 1'b0, 1'b0);
    step();
    expect_at(0, "clear_over", cyc, pack(0, 0, 0, 0, 0, 0, 1'b0, 2'd0), M_SG);
    ifa.clear = 1'b0;
    step();
    expect_at(0, "clear_over_after", cyc, pack(0, 0, 0, 0, 0, 0, 1'b0, 2'd0), M_SG);

    // clear vs point while playing
    set_pts(0, 1'b1, 1'b0);
    step();
    ifa.clear = 1'b1;
    set_pts(0, 1'b0, 1'b0);
    step();
    expect_at(0, "clear_play", cyc, pack(0, 0, 0, 0, 0, 0, 1'b0, 2'd0), M_SG);
    ifa.clear = 1'b0;
    step();
    expect_at(0, "clear_play_after", cyc, pack(0, 0, 0, 0, 0, 0, 1'b0, 2'd0), M_SG);
    pulse(0, 1'b1, 1'b0);
    expect_at(0, "count_after_clear", cyc, pack(0, 1, 0, 0, 0, 0, 1'b0, 2'd0), M_SG);

    // scan timing is untouched by clear
    for (int k = 0; k < 4; k++) begin
      e_sel = 2'(((cyc - rst_edge) / 4) % 4);
      expect_at(0, "scan_after_clear", cyc, pack(0, 0, 0, 0, e_sel, an_a[e_sel], 1'b0, 2'd0),
                M_SCAN);
      step();
    end

    // drive p1 to 99 on the WIN_SCORE=99 instance
    for (int i = 0; i < 87; i++) pulse(1, 1'b1, 1'b0);
    expect_at(1, "reach_99", cyc, pack(9, 9, 0, 5, 0, 0, 1'b1, 2'd1), M_SG);
    pulse(1, 1'b1, 1'b0);
    expect_at(1, "hold_99", cyc, pack(9, 9, 0, 5, 0, 0, 1'b1, 2'd1), M_SG);

    // mid-slot reset (sel=1, prescaler mid-count)
    for (int k = 0; k < 16 && ((cyc - rst_edge) % 16) != 6; k++) step();
    expect_at(1, "pre_rst", cyc, pack(9, 9, 0, 5, 2'd1, 4'hB, 1'b1, 2'd1), M_ALL);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rst_edge = cyc;
    expect_at(1, "rst_mid", cyc, pack(0, 0, 0, 0, 2'd0, 4'hF, 1'b0, 2'd0), M_ALL);
    expect_at(1, "first_sel_pre", rst_edge + 3, pack(0, 0, 0, 0, 2'd0, 4'hF, 1'b0, 2'd0), M_ALL);
    expect_at(1, "first_sel", rst_edge + 4, pack(0, 0, 0, 0, 2'd1, 4'hB, 1'b0, 2'd0), M_ALL);
    step(8);

    // expired-wait check: every queued expectation must have been compared
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL expired: %0d expectation(s) never checked", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
